// File: rtl/pe_arb_pkg.sv
// Shared types and constants for the PE access arbiter: FSM states,
// requester indices and the read-pipe slot layout.
package pe_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    localparam int REQ_UART = 0;
    localparam int REQ_SER  = 1;

    typedef struct packed {
        logic valid;
        logic tag;
    } rd_slot_t;

    function automatic logic [1:0] onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/pe_access_arbiter_rd_valid_pipe.sv
// Fixed-latency return path for read strobes: a shift register of
// {valid, requester tag} decoded into per-requester rd_valid bits.
module rd_valid_pipe
    import pe_arb_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic       in_tag,
    output logic [1:0] rd_valid
);

    rd_slot_t pipe [RD_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: in_valid, tag: in_tag};
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign rd_valid = pipe[RD_LAT-1].valid ? onehot(pipe[RD_LAT-1].tag) : 2'b00;

endmodule

// File: rtl/pe_access_arbiter.sv
// Round-robin, transaction-holding arbiter between the UART and serial
// controllers for the single PE controller port, with an idle watchdog.
module pe_access_arbiter
    import pe_arb_pkg::*;
#(
    parameter int DIN_W   = 256,
    parameter int WT_W    = 1024,
    parameter int ADDR_W  = 4,
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    output logic [1:0]        gnt,
    input  logic [1:0]        new_din,
    input  logic [1:0]        new_wt,
    input  logic [DIN_W-1:0]  din0,
    input  logic [DIN_W-1:0]  din1,
    input  logic [WT_W-1:0]   wtin0,
    input  logic [WT_W-1:0]   wtin1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [1:0]        rd_req,
    output logic [1:0]        rd_valid,
    output logic              pe_new_din,
    output logic              pe_new_wt,
    output logic [DIN_W-1:0]  pe_din,
    output logic [WT_W-1:0]   pe_wtin,
    output logic [ADDR_W-1:0] pe_addr,
    output logic [1:0]        drop_err,
    output logic              timeout_err,
    input  logic              err_clr
);

    localparam int              CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]       DRAIN_LIM = 3'(RD_LAT);

    arb_state_t       state, state_nxt;
    logic             g, g_nxt;
    logic             ptr, ptr_nxt;
    logic [1:0]       mask, mask_set;
    logic [CNT_W-1:0] idle_cnt, idle_nxt;
    logic [2:0]       drain_cnt, drain_nxt;
    logic [1:0]       gnt_nxt;
    logic [1:0]       eligible;
    logic             activity;
    logic             timeout_set;
    logic             granted;
    logic             fwd_din, fwd_wt, fwd_rd;
    logic [1:0]       drop_set;
    logic             rd_fire, rd_tag;

    assign granted  = (state == GRANT);
    assign eligible = req & ~mask;
    assign activity = new_din[g] | new_wt[g] | rd_req[g];
    assign fwd_din  = granted & new_din[g];
    assign fwd_wt   = granted & new_wt[g];
    assign fwd_rd   = granted & rd_req[g];
    assign drop_set = (new_din | new_wt | rd_req) & ~gnt;

    always_comb begin
        state_nxt   = state;
        g_nxt       = g;
        ptr_nxt     = ptr;
        idle_nxt    = idle_cnt;
        drain_nxt   = drain_cnt;
        mask_set    = 2'b00;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (eligible != 2'b00) begin
                    state_nxt = GRANT;
                    g_nxt     = eligible[ptr] ? ptr : ~ptr;
                    idle_nxt  = '0;
                end
            end
            GRANT: begin
                // A release wins over the watchdog so a clean hand-back never flags an error.
                if (!req[g]) begin
                    state_nxt = DRAIN;
                    drain_nxt = '0;
                end else if (activity) begin
                    idle_nxt = '0;
                end else if (idle_cnt >= IDLE_LIM) begin
                    state_nxt   = DRAIN;
                    drain_nxt   = '0;
                    timeout_set = 1'b1;
                    mask_set    = onehot(g);
                end else begin
                    idle_nxt = idle_cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LIM) begin
                    state_nxt = IDLE;
                    ptr_nxt   = ~g;
                end else begin
                    drain_nxt = drain_cnt + 3'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        gnt_nxt = (state_nxt == GRANT) ? onehot(g_nxt) : 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            g         <= 1'b0;
            ptr       <= 1'b0;
            mask      <= 2'b00;
            idle_cnt  <= '0;
            drain_cnt <= '0;
            gnt       <= 2'b00;
        end else begin
            state     <= state_nxt;
            g         <= g_nxt;
            ptr       <= ptr_nxt;
            mask      <= (mask | mask_set) & req;
            idle_cnt  <= idle_nxt;
            drain_cnt <= drain_nxt;
            gnt       <= gnt_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe_new_din <= 1'b0;
            pe_new_wt  <= 1'b0;
            pe_din     <= '0;
            pe_wtin    <= '0;
            pe_addr    <= '0;
            rd_fire    <= 1'b0;
            rd_tag     <= 1'b0;
        end else begin
            pe_new_din <= fwd_din;
            pe_new_wt  <= fwd_wt;
            if (fwd_din) begin
                pe_din <= (g == 1'(REQ_SER)) ? din1 : din0;
            end
            if (fwd_wt) begin
                pe_wtin <= (g == 1'(REQ_SER)) ? wtin1 : wtin0;
            end
            if (granted) begin
                pe_addr <= (g == 1'(REQ_SER)) ? addr1 : addr0;
            end
            rd_fire <= fwd_rd;
            rd_tag  <= g;
        end
    end

    // Clear takes priority so software can acknowledge even while errors keep occurring.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_err    <= 2'b00;
            timeout_err <= 1'b0;
        end else if (err_clr) begin
            drop_err    <= 2'b00;
            timeout_err <= 1'b0;
        end else begin
            drop_err    <= drop_err | drop_set;
            timeout_err <= timeout_err | timeout_set;
        end
    end

    rd_valid_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_valid_pipe (
        .clk      (clk),
        .reset    (reset),
        .in_valid (rd_fire),
        .in_tag   (rd_tag),
        .rd_valid (rd_valid)
    );

endmodule

// File: tb/tb_pe_access_arbiter.sv
// Self-checking bench: directed test-plan scenarios then randomized traffic,
// compared every cycle against a transaction-level reference model.
module tb_pe_access_arbiter;

    localparam int DIN_W   = 64;
    localparam int WT_W    = 96;
    localparam int ADDR_W  = 4;
    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [1:0]        req = '0;
    logic [1:0]        gnt;
    logic [1:0]        new_din = '0;
    logic [1:0]        new_wt = '0;
    logic [DIN_W-1:0]  din0 = '0, din1 = '0;
    logic [WT_W-1:0]   wtin0 = '0, wtin1 = '0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [1:0]        rd_req = '0;
    logic [1:0]        rd_valid;
    logic              pe_new_din, pe_new_wt;
    logic [DIN_W-1:0]  pe_din;
    logic [WT_W-1:0]   pe_wtin;
    logic [ADDR_W-1:0] pe_addr;
    logic [1:0]        drop_err;
    logic              timeout_err;
    logic              err_clr = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;

    pe_access_arbiter #(
        .DIN_W   (DIN_W),
        .WT_W    (WT_W),
        .ADDR_W  (ADDR_W),
        .RD_LAT  (RD_LAT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .gnt         (gnt),
        .new_din     (new_din),
        .new_wt      (new_wt),
        .din0        (din0),
        .din1        (din1),
        .wtin0       (wtin0),
        .wtin1       (wtin1),
        .addr0       (addr0),
        .addr1       (addr1),
        .rd_req      (rd_req),
        .rd_valid    (rd_valid),
        .pe_new_din  (pe_new_din),
        .pe_new_wt   (pe_new_wt),
        .pe_din      (pe_din),
        .pe_wtin     (pe_wtin),
        .pe_addr     (pe_addr),
        .drop_err    (drop_err),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the port, how long the hand-back still lasts,
    // and a queue of read completions keyed by absolute edge number.
    int              owner;
    int              last_owner;
    int              prio;
    int              quiet;
    int              drain_left;
    bit              locked [2];
    int              edge_n;
    int              rd_at [$];
    int              rd_tg [$];
    logic [1:0]      m_gnt, m_rv, m_derr;
    logic            m_terr, m_pnd, m_pnw;
    logic [DIN_W-1:0]  m_din;
    logic [WT_W-1:0]   m_wt;
    logic [ADDR_W-1:0] m_addr;

    task automatic model_reset();
        owner = -1; last_owner = 0; prio = 0; quiet = 0; drain_left = 0;
        locked[0] = 0; locked[1] = 0;
        rd_at.delete(); rd_tg.delete();
        m_gnt = 0; m_rv = 0; m_derr = 0; m_terr = 0; m_pnd = 0; m_pnw = 0;
        m_din = '0; m_wt = '0; m_addr = '0;
    endtask

    task automatic release_port();
        last_owner = owner;
        owner      = -1;
        drain_left = RD_LAT + 1;
    endtask

    task automatic model_step();
        logic [1:0] drop_set;
        logic       to_set;
        logic [1:0] rv;
        bit         act;
        bit         elig [2];
        edge_n++;
        drop_set = 0;
        to_set   = 0;
        for (int i = 0; i < 2; i++)
            if ((new_din[i] | new_wt[i] | rd_req[i]) && owner != i) drop_set[i] = 1'b1;
        m_pnd = 0;
        m_pnw = 0;
        if (owner >= 0) begin
            if (new_din[owner]) begin m_pnd = 1; m_din = (owner == 1) ? din1 : din0; end
            if (new_wt[owner])  begin m_pnw = 1; m_wt  = (owner == 1) ? wtin1 : wtin0; end
            m_addr = (owner == 1) ? addr1 : addr0;
            if (rd_req[owner]) begin rd_at.push_back(edge_n + RD_LAT); rd_tg.push_back(owner); end
            act = new_din[owner] | new_wt[owner] | rd_req[owner];
            if (!req[owner]) release_port();
            else if (act) quiet = 0;
            else if (quiet >= TIMEOUT - 1) begin
                to_set = 1;
                locked[owner] = 1;
                release_port();
            end else quiet++;
        end else if (drain_left > 0) begin
            drain_left--;
            if (drain_left == 0) prio = 1 - last_owner;
        end else begin
            for (int i = 0; i < 2; i++) elig[i] = req[i] && !locked[i];
            if (elig[prio]) owner = prio;
            else if (elig[1-prio]) owner = 1 - prio;
            quiet = 0;
        end
        for (int i = 0; i < 2; i++) locked[i] = locked[i] && req[i];
        if (err_clr) begin m_derr = 0; m_terr = 0; end
        else begin m_derr = m_derr | drop_set; m_terr = m_terr | to_set; end
        rv = 0;
        while (rd_at.size() > 0 && rd_at[0] <= edge_n) begin
            if (rd_at[0] == edge_n) rv[rd_tg[0]] = 1'b1;
            void'(rd_at.pop_front());
            void'(rd_tg.pop_front());
        end
        m_rv  = rv;
        m_gnt = (owner < 0) ? 2'b00 : ((owner == 1) ? 2'b10 : 2'b01);
    endtask

    task automatic cmp(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_output();
        cmp("gnt",         128'(gnt),         128'(m_gnt));
        cmp("pe_new_din",  128'(pe_new_din),  128'(m_pnd));
        cmp("pe_new_wt",   128'(pe_new_wt),   128'(m_pnw));
        cmp("pe_din",      128'(pe_din),      128'(m_din));
        cmp("pe_wtin",     128'(pe_wtin),     128'(m_wt));
        cmp("pe_addr",     128'(pe_addr),     128'(m_addr));
        cmp("rd_valid",    128'(rd_valid),    128'(m_rv));
        cmp("drop_err",    128'(drop_err),    128'(m_derr));
        cmp("timeout_err", 128'(timeout_err), 128'(m_terr));
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_step();
        #1;
        check_output();
    endtask

    task automatic apply_stimulus(input logic [1:0] r, input logic [1:0] nd,
                                  input logic [1:0] nw, input logic [1:0] rr,
                                  input logic clr);
        req     = r;
        new_din = nd;
        new_wt  = nw;
        rd_req  = rr;
        err_clr = clr;
        step_cycle();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_output();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic idle_cycles(input logic [1:0] r, input int n);
        for (int i = 0; i < n; i++) apply_stimulus(r, 2'b00, 2'b00, 2'b00, 1'b0);
    endtask

    logic [1:0] rnd_req;
    logic [1:0] nd, nw, rr;
    bit         busy;

    initial begin
        edge_n = 0;
        $display("[TB] start");
        do_reset();

        // Single requester with a data-load pulse, then back-to-back loads.
        din0 = {8{8'hA5}};
        apply_stimulus(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        apply_stimulus(2'b01, 2'b00, 2'b00, 2'b00, 1'b0);
        din0 = 64'h0123_4567_89AB_CDEF;
        wtin0 = {3{32'hDEAD_BEEF}};
        apply_stimulus(2'b01, 2'b01, 2'b01, 2'b00, 1'b0);
        din0 = 64'hFEDC_BA98_7654_3210;
        apply_stimulus(2'b01, 2'b01, 2'b00, 2'b00, 1'b0);
        din0 = '0;
        apply_stimulus(2'b00, 2'b01, 2'b00, 2'b00, 1'b0);
        idle_cycles(2'b00, RD_LAT + 3);

        // Contention: both rise together, then release and re-contend.
        apply_stimulus(2'b11, 2'b00, 2'b00, 2'b00, 1'b0);
        idle_cycles(2'b11, 2);
        idle_cycles(2'b10, RD_LAT + 4);
        idle_cycles(2'b00, RD_LAT + 3);
        idle_cycles(2'b11, 3);
        idle_cycles(2'b00, RD_LAT + 3);

        // Read from requester 1 at address 5.
        addr1 = 4'd5;
        idle_cycles(2'b10, 2);
        apply_stimulus(2'b10, 2'b00, 2'b00, 2'b10, 1'b0);
        addr1 = 4'd9;
        idle_cycles(2'b10, RD_LAT + 2);

        // Non-granted pulse is dropped, then cleared.
        idle_cycles(2'b00, RD_LAT + 3);
        idle_cycles(2'b01, 2);
        wtin1 = {3{32'h1234_5678}};
        apply_stimulus(2'b01, 2'b00, 2'b10, 2'b00, 1'b0);
        idle_cycles(2'b01, 1);
        apply_stimulus(2'b01, 2'b00, 2'b10, 2'b00, 1'b1);
        idle_cycles(2'b01, 1);

        // Watchdog: requester 0 goes quiet, gets revoked and stays locked out.
        idle_cycles(2'b01, TIMEOUT + RD_LAT + 6);
        idle_cycles(2'b00, 1);
        idle_cycles(2'b01, 4);
        apply_stimulus(2'b00, 2'b00, 2'b00, 2'b00, 1'b1);
        idle_cycles(2'b00, RD_LAT + 3);

        // Reset one cycle after a read request: the completion must vanish.
        idle_cycles(2'b01, 2);
        apply_stimulus(2'b01, 2'b00, 2'b00, 2'b01, 1'b0);
        idle_cycles(2'b01, 1);
        do_reset();
        idle_cycles(2'b00, RD_LAT + 3);

        // Randomized traffic with alternating busy and quiet stretches.
        rnd_req = 2'b00;
        busy    = 1'b1;
        for (int c = 0; c < 800; c++) begin
            if (c % 40 == 0) busy = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 15) == 0) rnd_req[i] = ~rnd_req[i];
                nd[i] = busy && ($urandom_range(0, 3) == 0);
                nw[i] = busy && ($urandom_range(0, 3) == 0);
                rr[i] = busy && ($urandom_range(0, 3) == 0);
            end
            din0  = {$urandom(), $urandom()};
            din1  = {$urandom(), $urandom()};
            wtin0 = {$urandom(), $urandom(), $urandom()};
            wtin1 = {$urandom(), $urandom(), $urandom()};
            addr0 = 4'($urandom_range(0, 15));
            addr1 = 4'($urandom_range(0, 15));
            apply_stimulus(rnd_req, nd, nw, rr, ($urandom_range(0, 31) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_access_arbiter.md
# pe_access_arbiter

Arbitrates between the two host-side controllers (UART command controller, requester 0; serial shift controller, requester 1) for the single PE controller port. It replaces the static mode-select mux with a round-robin, transaction-holding grant. Only the granted requester's load pulses, data and read address reach the PE controller, and read-valid strobes are returned to it at a fixed latency. A per-grant inactivity watchdog reclaims the port from a stalled requester.

## Interface
Parameters:
- DIN_W, 256, width of PE data-in bus
- WT_W, 1024, width of PE weight bus
- ADDR_W, 4, PE output-buffer address width
- RD_LAT, 2, PE dout latency in cycles from registered address to valid data (1..7)
- TIMEOUT, 1024, idle cycles allowed while granted before forced revoke (≥2)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  2  per-requester port request, level, held for whole transaction
- gnt  out  2  one-hot-or-zero grant, registered
- new_din  in  2  per-requester data-load pulse
- new_wt  in  2  per-requester weight-load pulse
- din0, din1  in  DIN_W  requester data buses
- wtin0, wtin1  in  WT_W  requester weight buses
- addr0, addr1  in  ADDR_W  requester read addresses
- rd_req  in  2  per-requester read strobe (addr sampled same cycle)
- rd_valid  out  2  dout valid for that requester
- pe_new_din, pe_new_wt  out  1  load pulses to PE controller
- pe_din  out  DIN_W; pe_wtin  out  WT_W; pe_addr  out  ADDR_W
- drop_err  out  2  sticky: pulse from a non-granted requester discarded
- timeout_err  out  1  sticky: watchdog revoked a grant
- err_clr  in  1  clears drop_err and timeout_err

## Operation
- States: IDLE, GRANT, DRAIN. Register g (granted index), ptr (priority index).
- IDLE: if req & ~mask nonzero, pick ptr first else the other; next cycle GRANT, gnt[g]=1. None: stay.
- GRANT: forwards new_din[g], new_wt[g], din/wtin/addr of g. req[g]=0 → DRAIN. Idle counter ≥ TIMEOUT-1 with no activity → DRAIN, timeout_err=1, mask[g]=1.
- Activity = new_din[g] | new_wt[g] | rd_req[g]; resets idle counter. Counter cleared on entering GRANT.
- DRAIN: gnt=0, no pulses forwarded, lasts RD_LAT+1 cycles so the read pipeline empties; then IDLE with ptr = ~g.
- mask[i] clears when req[i] is seen low; masked requester cannot be granted.
- Any new_din/new_wt/rd_req from a requester without gnt: discarded, drop_err[i]=1.
- err_clr has priority over set in the same cycle.
- pe_din / pe_wtin update only on a forwarded pulse; otherwise hold.

## Timing
- Reset: state IDLE, ptr=0, g=0, mask=0, gnt=0, pe_new_din=pe_new_wt=0, pe_din=pe_wtin=pe_addr=0, rd_valid=0, errors=0, counters 0.
- req rise to gnt: 1 cycle (IDLE sample, gnt registered next edge).
- Forwarded pulse: pe_new_* and data register 1 cycle after input pulse; pulse width 1 per input pulse; back-to-back pulses pass every cycle.
- pe_addr registered from addr[g] every GRANT cycle.
- rd_req[g] at cycle t → rd_valid[g] high exactly at t+1+RD_LAT, one cycle, via shift pipe tagged with g.
- Simultaneous req rise on both: ptr requester wins; other waits through DRAIN.
- req[g] dropping same cycle as a pulse: pulse forwarded, then DRAIN.
- Watchdog and req drop same cycle: treated as normal release, no error.
- Async reset mid-transaction: everything returns to reset values immediately; in-flight rd_valid lost.

## Structure
- Package pe_arb_pkg: state enum (IDLE, GRANT, DRAIN), requester index constants REQ_UART=0, REQ_SER=1.
- Sub-module rd_valid_pipe: RD_LAT-deep shift register of {valid, tag}, decoded to rd_valid[1:0].
- Watchdog counter width $clog2(TIMEOUT+1), inline.

## Test plan
- Single requester: req[0]=1, new_din pulse with din0=0xA5..A5 → gnt=01 next cycle, pe_new_din 1-cycle pulse with pe_din=0xA5..A5.
- Contention: req=11 from reset → gnt=01; req[0] drops → gnt=00 for RD_LAT+1 cycles, then gnt=10; next contention grants 01 again.
- Read: granted requester 1, addr1=5, rd_req[1] at t → pe_addr=5 at t+1, rd_valid=10 only at t+3 (RD_LAT=2).
- Drop: gnt=01, new_wt[1] pulse → pe_new_wt stays 0, drop_err=10; err_clr → 00.
- Timeout (TIMEOUT=8): req[0] held, no activity → gnt drops after 8 idle cycles, timeout_err=1, req[0] still high not re-granted until it falls and rises.
- Reset mid-read: assert reset one cycle after rd_req → rd_valid never asserts, all outputs zero.
